// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, ALU codes,
// datapath select constants, FSM states and the control-word payload.
package multicycle_controller_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_W   = 7;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned SRC_SEL_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_LD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SD   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 7'b1100011;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;

  localparam logic [SRC_SEL_W-1:0] SRC_A_PC     = 2'b00;
  localparam logic [SRC_SEL_W-1:0] SRC_A_RS1    = 2'b01;
  localparam logic [SRC_SEL_W-1:0] SRC_A_OLD_PC = 2'b10;
  localparam logic [SRC_SEL_W-1:0] SRC_B_RS2    = 2'b00;
  localparam logic [SRC_SEL_W-1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [SRC_SEL_W-1:0] SRC_B_IMM    = 2'b10;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC_R,
    EXEC_I,
    ALUWB,
    BEQ,
    ILLEGAL
  } state_t;

  // Control word driven towards the datapath (illegal flag kept separately).
  typedef struct packed {
    logic                  pc_write;
    logic                  pc_src;
    logic                  ir_write;
    logic                  iord;
    logic                  mem_read;
    logic                  mem_write;
    logic [SRC_SEL_W-1:0]  alu_src_a;
    logic [SRC_SEL_W-1:0]  alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  instr_done;
  } ctl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_controller_if;
  import multicycle_controller_pkg::*;

  logic [OPCODE_W-1:0]   opcode;
  logic [FUNCT3_W-1:0]   funct3;
  logic [FUNCT7_W-1:0]   funct7;
  logic                  zero;
  logic                  mem_ready;

  logic                  pc_write;
  logic                  pc_src;
  logic                  ir_write;
  logic                  iord;
  logic                  mem_read;
  logic                  mem_write;
  logic [SRC_SEL_W-1:0]  alu_src_a;
  logic [SRC_SEL_W-1:0]  alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  reg_write;
  logic                  mem_to_reg;
  logic                  instr_done;
  logic                  illegal_instr;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write,
           alu_src_a, alu_src_b, alu_control, reg_write, mem_to_reg,
           instr_done, illegal_instr
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write,
           alu_src_a, alu_src_b, alu_control, reg_write, mem_to_reg,
           instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type ALU decoder: maps (funct3, funct7) to an ALU op and flags
// combinations the datapath does not implement.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [FUNCT3_W-1:0]   funct3,
  input  logic [FUNCT7_W-1:0]   funct7,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  r_legal
);

  always_comb begin
    alu_control = ALU_ADD;
    r_legal     = 1'b0;
    case ({funct7, funct3})
      {7'b0000000, 3'b000}: begin alu_control = ALU_ADD; r_legal = 1'b1; end
      {7'b0100000, 3'b000}: begin alu_control = ALU_SUB; r_legal = 1'b1; end
      {7'b0000000, 3'b111}: begin alu_control = ALU_AND; r_legal = 1'b1; end
      {7'b0000000, 3'b110}: begin alu_control = ALU_OR;  r_legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the shared-memory datapath. Outputs are decoded
// from state (plus mem_ready/zero for the PC/IR/done strobes) and forced low
// during reset so a reset cycle drops any in-flight memory request at once.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  state_t                state;
  state_t                state_nxt;
  ctl_t                  ctl;
  ctl_t                  ctl_out;
  logic                  illegal_q;
  logic [ALU_CTRL_W-1:0] r_alu_control;
  logic                  r_legal;

  alu_decoder u_alu_decoder (
    .funct3      (bus.funct3),
    .funct7      (bus.funct7),
    .alu_control (r_alu_control),
    .r_legal     (r_legal)
  );

  // State and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= (state_nxt == ILLEGAL);
    end
  end

  // Next state and control word.
  always_comb begin
    state_nxt       = state;
    ctl             = '0;
    ctl.alu_control = ALU_ADD;
    case (state)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_a = SRC_A_PC;
        ctl.alu_src_b = SRC_B_FOUR;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_nxt    = DECODE;
        end
      end
      DECODE: begin
        ctl.alu_src_a = SRC_A_OLD_PC;
        ctl.alu_src_b = SRC_B_IMM;
        case (bus.opcode)
          OP_LD, OP_SD: state_nxt = MEMADR;
          OP_R:         state_nxt = r_legal ? EXEC_R : ILLEGAL;
          OP_ADDI:      state_nxt = EXEC_I;
          OP_BEQ:       state_nxt = BEQ;
          default:      state_nxt = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ctl.alu_src_a = SRC_A_RS1;
        ctl.alu_src_b = SRC_B_IMM;
        state_nxt     = (bus.opcode == OP_SD) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (bus.mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = FETCH;
      end
      MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (bus.mem_ready) begin
          ctl.instr_done = 1'b1;
          state_nxt      = FETCH;
        end
      end
      EXEC_R: begin
        ctl.alu_src_a   = SRC_A_RS1;
        ctl.alu_src_b   = SRC_B_RS2;
        ctl.alu_control = r_alu_control;
        state_nxt       = ALUWB;
      end
      EXEC_I: begin
        ctl.alu_src_a = SRC_A_RS1;
        ctl.alu_src_b = SRC_B_IMM;
        state_nxt     = ALUWB;
      end
      ALUWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = FETCH;
      end
      BEQ: begin
        ctl.alu_src_a   = SRC_A_RS1;
        ctl.alu_src_b   = SRC_B_RS2;
        ctl.alu_control = ALU_SUB;
        ctl.pc_src      = 1'b1;
        ctl.pc_write    = bus.zero;
        ctl.instr_done  = 1'b1;
        state_nxt       = FETCH;
      end
      ILLEGAL: begin
        ctl.alu_control = '0;
      end
      default: state_nxt = ILLEGAL;
    endcase
  end

  assign ctl_out = rst ? '0 : ctl;

  assign bus.pc_write      = ctl_out.pc_write;
  assign bus.pc_src        = ctl_out.pc_src;
  assign bus.ir_write      = ctl_out.ir_write;
  assign bus.iord          = ctl_out.iord;
  assign bus.mem_read      = ctl_out.mem_read;
  assign bus.mem_write     = ctl_out.mem_write;
  assign bus.alu_src_a     = ctl_out.alu_src_a;
  assign bus.alu_src_b     = ctl_out.alu_src_b;
  assign bus.alu_control   = ctl_out.alu_control;
  assign bus.reg_write     = ctl_out.reg_write;
  assign bus.mem_to_reg    = ctl_out.mem_to_reg;
  assign bus.instr_done    = ctl_out.instr_done;
  assign bus.illegal_instr = illegal_q & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-accurate scoreboard bench for multicycle_controller: each driven cycle
// queues the expected control vector, which is compared at the falling edge.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit order: pw ps irw iord mr mw a[2] b[2] alu[3] rw m2r done ill
  function automatic logic [17:0] vec(input logic pw, ps, irw, iord, mr, mw,
                                      input logic [1:0] a, b, input logic [2:0] alu,
                                      input logic rw, m2r, done, ill);
    return {1'b0, pw, ps, irw, iord, mr, mw, a, b, alu, rw, m2r, done, ill};
  endfunction

  function automatic logic [17:0] observed();
    return {1'b0, bus.pc_write, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read,
            bus.mem_write, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
            bus.reg_write, bus.mem_to_reg, bus.instr_done, bus.illegal_instr};
  endfunction

  function automatic logic [17:0] e_fetch(input logic rdy);
    return vec(rdy, 0, rdy, 0, 1, 0, 2'b00, 2'b01, 3'b010, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_decode();
    return vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 3'b010, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_rs1_imm();
    return vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b010, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_memrd();
    return vec(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_memwb();
    return vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 1, 1, 1, 0);
  endfunction
  function automatic logic [17:0] e_memwr(input logic rdy);
    return vec(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 3'b010, 0, 0, rdy, 0);
  endfunction
  function automatic logic [17:0] e_exec_r(input logic [2:0] alu);
    return vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, alu, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_aluwb();
    return vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 1, 0, 1, 0);
  endfunction
  function automatic logic [17:0] e_beq(input logic z);
    return vec(z, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b110, 0, 0, 1, 0);
  endfunction
  function automatic logic [17:0] e_illegal();
    return vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0, 1);
  endfunction

  // One clock of stimulus plus its queued expectation.
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic z,
                     input logic [17:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst           = r;
    bus.mem_ready = rdy;
    bus.zero      = z;
    x.tag = tag;
    x.v   = e;
    sb_q.push_back(x);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      check(x.tag, 32'(observed()), 32'(x.v));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    set_instr(7'b0, 3'b0, 7'b0);
    rst = 1'b1;

    cyc("rst0", 1, 0, 0, '0);
    cyc("rst1", 1, 1, 0, '0);

    // ADDI, memory always ready
    set_instr(7'b0010011, 3'b000, 7'b0000000);
    cyc("addi_fetch", 0, 1, 0, e_fetch(1));
    cyc("addi_decode", 0, 1, 0, e_decode());
    cyc("addi_exec", 0, 1, 0, e_rs1_imm());
    cyc("addi_wb", 0, 1, 0, e_aluwb());

    // LD with one fetch wait and three MEMRD waits
    set_instr(7'b0000011, 3'b011, 7'b0000000);
    cyc("ld_fetch_wait", 0, 0, 0, e_fetch(0));
    cyc("ld_fetch", 0, 1, 0, e_fetch(1));
    cyc("ld_decode", 0, 1, 0, e_decode());
    cyc("ld_memadr", 0, 1, 0, e_rs1_imm());
    for (int i = 0; i < 3; i++) cyc("ld_memrd_wait", 0, 0, 0, e_memrd());
    cyc("ld_memrd", 0, 1, 0, e_memrd());
    cyc("ld_memwb", 0, 1, 0, e_memwb());

    // SD, memory always ready
    set_instr(7'b0100011, 3'b011, 7'b0000000);
    cyc("sd_fetch", 0, 1, 0, e_fetch(1));
    cyc("sd_decode", 0, 1, 0, e_decode());
    cyc("sd_memadr", 0, 1, 0, e_rs1_imm());
    cyc("sd_memwr", 0, 1, 0, e_memwr(1));

    // BEQ taken then not taken
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_t_fetch", 0, 1, 0, e_fetch(1));
    cyc("beq_t_decode", 0, 1, 0, e_decode());
    cyc("beq_taken", 0, 1, 1, e_beq(1));
    cyc("beq_n_fetch", 0, 1, 0, e_fetch(1));
    cyc("beq_n_decode", 0, 1, 0, e_decode());
    cyc("beq_not_taken", 0, 1, 0, e_beq(0));

    // R-type SUB, AND, OR
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    cyc("sub_fetch", 0, 1, 0, e_fetch(1));
    cyc("sub_decode", 0, 1, 0, e_decode());
    cyc("sub_exec", 0, 1, 0, e_exec_r(3'b110));
    cyc("sub_wb", 0, 1, 0, e_aluwb());
    set_instr(7'b0110011, 3'b111, 7'b0000000);
    cyc("and_fetch", 0, 1, 0, e_fetch(1));
    cyc("and_decode", 0, 1, 0, e_decode());
    cyc("and_exec", 0, 1, 0, e_exec_r(3'b000));
    cyc("and_wb", 0, 1, 0, e_aluwb());
    set_instr(7'b0110011, 3'b110, 7'b0000000);
    cyc("or_fetch", 0, 1, 0, e_fetch(1));
    cyc("or_decode", 0, 1, 0, e_decode());
    cyc("or_exec", 0, 1, 0, e_exec_r(3'b001));
    cyc("or_wb", 0, 1, 0, e_aluwb());

    // Unsupported funct7 traps and stays trapped until reset
    set_instr(7'b0110011, 3'b000, 7'b0000001);
    cyc("badr_fetch", 0, 1, 0, e_fetch(1));
    cyc("badr_decode", 0, 1, 0, e_decode());
    for (int i = 0; i < 12; i++) cyc("badr_illegal", 0, 1, (i % 2) == 1, e_illegal());
    cyc("badr_rst", 1, 1, 0, '0);
    set_instr(7'b1111111, 3'b000, 7'b0000000);
    cyc("post_rst_fetch", 0, 1, 0, e_fetch(1));

    // Unknown opcode traps; one reset cycle recovers
    cyc("badop_decode", 0, 1, 0, e_decode());
    cyc("badop_illegal0", 0, 1, 0, e_illegal());
    cyc("badop_illegal1", 0, 0, 0, e_illegal());
    cyc("badop_rst", 1, 0, 0, '0);
    set_instr(7'b0100011, 3'b011, 7'b0000000);
    cyc("badop_fetch_wait", 0, 0, 0, e_fetch(0));

    // Reset during a MEMWR wait drops mem_write immediately
    cyc("sdr_fetch", 0, 1, 0, e_fetch(1));
    cyc("sdr_decode", 0, 0, 0, e_decode());
    cyc("sdr_memadr", 0, 0, 0, e_rs1_imm());
    cyc("sdr_memwr_wait0", 0, 0, 0, e_memwr(0));
    cyc("sdr_memwr_wait1", 0, 0, 0, e_memwr(0));
    cyc("sdr_rst", 1, 0, 0, '0);
    cyc("sdr_fetch_after", 0, 0, 0, e_fetch(0));
    cyc("sdr_fetch_ready", 0, 1, 0, e_fetch(1));

    @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
